// File: rtl/periph_regfile_pkg.sv
// Shared constants for the peripheral register bank: address offsets, byte-lane positions, reset defaults.
// Pure declarations; no timing or flow control of its own.
package periph_regfile_pkg;

    localparam int CH_STRIDE = 4;

    localparam logic [7:0] CFG_RST_DEF = 8'd17;

    // Byte lanes of a channel word and the byte enable that guards each writable lane
    localparam int STATUS_LSB = 0;
    localparam int SEND_LSB   = 8;
    localparam int RCVD_LSB   = 16;
    localparam int CFG_LSB    = 24;
    localparam int SEND_BE    = 1;
    localparam int CFG_BE     = 3;
    localparam int IRQ_BE     = 0;

    function automatic int led_ofs(input int n_ch);
        return CH_STRIDE * n_ch;
    endfunction

    function automatic int irq_stat_ofs(input int n_ch);
        return CH_STRIDE * n_ch + 4;
    endfunction

    function automatic int irq_en_ofs(input int n_ch);
        return CH_STRIDE * n_ch + 8;
    endfunction

endpackage

// File: rtl/periph_uart_ch_regs.sv
// One UART channel's registers: send byte + start strobe, config byte, sticky W1C interrupt bit.
// Writes land on the strobe edge; read word is combinational; never stalls.
module periph_uart_ch_regs
    import periph_regfile_pkg::*;
#(
    parameter logic [7:0] CFG_RST = CFG_RST_DEF
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        send_we,
    input  logic [7:0]  send_wdat,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_wdat,
    input  logic        irq_clr,
    input  logic        irq_evt,
    input  logic [7:0]  status,
    input  logic [7:0]  rcvd,
    output logic [7:0]  send_byte,
    output logic        send_pulse,
    output logic [7:0]  cfg,
    output logic        irq_stat,
    output logic [31:0] rd_word
);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            send_byte  <= '0;
            send_pulse <= 1'b0;
            cfg        <= CFG_RST;
            irq_stat   <= 1'b0;
        end else begin
            // Strobe fires on every send write, even when the byte value is unchanged
            send_pulse <= send_we;
            if (send_we) send_byte <= send_wdat;
            if (cfg_we)  cfg       <= cfg_wdat;
            irq_stat <= irq_evt | (irq_stat & ~irq_clr);
        end
    end

    always_comb begin
        rd_word                      = '0;
        rd_word[STATUS_LSB +: 8]     = status;
        rd_word[SEND_LSB   +: 8]     = send_byte;
        rd_word[RCVD_LSB   +: 8]     = rcvd;
        rd_word[CFG_LSB    +: 8]     = cfg;
    end

endmodule

// File: rtl/periph_regfile.sv
// Memory-mapped register bank for N_CH UART channels, LED field and per-channel interrupts.
// Read data registered with 1-cycle latency; writes single-cycle; no backpressure on either port.
module periph_regfile
    import periph_regfile_pkg::*;
#(
    parameter int          N_CH    = 2,
    parameter int          LED_W   = 4,
    parameter logic [7:0]  CFG_RST = CFG_RST_DEF,
    parameter int          ADDR_W  = 16
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [8*N_CH-1:0]   uart_status,
    input  logic [8*N_CH-1:0]   uart_rcvd_byte,
    output logic [8*N_CH-1:0]   uart_send_byte,
    output logic [N_CH-1:0]     uart_send_pulse,
    output logic [8*N_CH-1:0]   uart_cfg,
    output logic [LED_W-1:0]    led_b,
    input  logic [N_CH-1:0]     irq_evt,
    output logic                irq,
    input  logic                wr_en,
    input  logic [3:0]          be,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [31:0]         wdata,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [31:0]         rdata,
    output logic                rd_rdy
);

    localparam logic [ADDR_W-1:0] LED_ADDR      = ADDR_W'(led_ofs(N_CH));
    localparam logic [ADDR_W-1:0] IRQ_STAT_ADDR = ADDR_W'(irq_stat_ofs(N_CH));
    localparam logic [ADDR_W-1:0] IRQ_EN_ADDR   = ADDR_W'(irq_en_ofs(N_CH));

    logic [N_CH-1:0] irq_stat;
    logic [N_CH-1:0] irq_en;
    logic [31:0]     ch_word [N_CH];
    logic [31:0]     rd_word;
    logic [31:0]     be_bits;
    logic            stat_clr_hit;
    logic            unused_ok;

    assign be_bits      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign stat_clr_hit = wr_en && (wr_addr == IRQ_STAT_ADDR) && be[IRQ_BE];
    assign unused_ok    = ^{wdata, be_bits};

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam logic [ADDR_W-1:0] CH_ADDR = ADDR_W'(CH_STRIDE * c);
        logic ch_hit;
        assign ch_hit = wr_en && (wr_addr == CH_ADDR);

        periph_uart_ch_regs #(
            .CFG_RST (CFG_RST)
        ) u_ch (
            .clk        (clk),
            .rstb       (rstb),
            .send_we    (ch_hit && be[SEND_BE]),
            .send_wdat  (wdata[SEND_LSB +: 8]),
            .cfg_we     (ch_hit && be[CFG_BE]),
            .cfg_wdat   (wdata[CFG_LSB +: 8]),
            .irq_clr    (stat_clr_hit && wdata[c]),
            .irq_evt    (irq_evt[c]),
            .status     (uart_status[8*c +: 8]),
            .rcvd       (uart_rcvd_byte[8*c +: 8]),
            .send_byte  (uart_send_byte[8*c +: 8]),
            .send_pulse (uart_send_pulse[c]),
            .cfg        (uart_cfg[8*c +: 8]),
            .irq_stat   (irq_stat[c]),
            .rd_word    (ch_word[c])
        );
    end

    // Exact match against aligned offsets, so misaligned and unmapped addresses fall through to 0
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_addr == ADDR_W'(CH_STRIDE * c)) rd_word = ch_word[c];
        end
        if (rd_addr == LED_ADDR)      rd_word = 32'(led_b);
        if (rd_addr == IRQ_STAT_ADDR) rd_word = 32'(irq_stat);
        if (rd_addr == IRQ_EN_ADDR)   rd_word = 32'(irq_en);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            led_b  <= '0;
            irq_en <= '0;
            irq    <= 1'b0;
            rdata  <= '0;
            rd_rdy <= 1'b0;
        end else begin
            if (wr_en && (wr_addr == LED_ADDR))
                led_b <= (led_b & ~be_bits[LED_W-1:0]) | (wdata[LED_W-1:0] & be_bits[LED_W-1:0]);
            if (wr_en && (wr_addr == IRQ_EN_ADDR) && be[IRQ_BE])
                irq_en <= wdata[N_CH-1:0];
            irq    <= |(irq_stat & irq_en);
            rdata  <= rd_en ? rd_word : 32'd0;
            rd_rdy <= rd_en;
        end
    end

endmodule

// File: tb/tb_periph_regfile.sv
// Scenario tasks plus a randomized run, all checked against a register-map model of the bank.
module tb_periph_regfile;

    localparam int N_CH   = 2;
    localparam int LED_W  = 4;
    localparam int ADDR_W = 16;

    logic                clk = 1'b0;
    logic                rstb;
    logic [8*N_CH-1:0]   uart_status, uart_rcvd_byte;
    logic [8*N_CH-1:0]   uart_send_byte, uart_cfg;
    logic [N_CH-1:0]     uart_send_pulse, irq_evt;
    logic [LED_W-1:0]    led_b;
    logic                irq, wr_en, rd_en, rd_rdy;
    logic [3:0]          be;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic [31:0]         wdata, rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    periph_regfile #(
        .N_CH (N_CH), .LED_W (LED_W), .CFG_RST (8'd17), .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk), .rstb (rstb),
        .uart_status (uart_status), .uart_rcvd_byte (uart_rcvd_byte),
        .uart_send_byte (uart_send_byte), .uart_send_pulse (uart_send_pulse),
        .uart_cfg (uart_cfg), .led_b (led_b), .irq_evt (irq_evt), .irq (irq),
        .wr_en (wr_en), .be (be), .wr_addr (wr_addr), .wdata (wdata),
        .rd_en (rd_en), .rd_addr (rd_addr), .rdata (rdata), .rd_rdy (rd_rdy)
    );

    // Reference model: register contents as plain arrays
    logic [7:0]        m_send [N_CH];
    logic [7:0]        m_cfg  [N_CH];
    logic [N_CH-1:0]   m_pulse, m_stat, m_en;
    logic [LED_W-1:0]  m_led;
    logic              m_irq, m_rdy;
    logic [31:0]       m_rdata;

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_send[c] = 8'h00;
            m_cfg[c]  = 8'd17;
        end
        m_pulse = '0; m_stat = '0; m_en = '0; m_led = '0;
        m_irq = 1'b0; m_rdy = 1'b0; m_rdata = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
        int w;
        if (a % 4 != 0) return 32'd0;
        w = int'(a) / 4;
        if (w < N_CH)
            return {m_cfg[w], uart_rcvd_byte[8*w +: 8], m_send[w], uart_status[8*w +: 8]};
        if (w == N_CH)     return 32'(m_led);
        if (w == N_CH + 1) return 32'(m_stat);
        if (w == N_CH + 2) return 32'(m_en);
        return 32'd0;
    endfunction

    function automatic logic [8*N_CH-1:0] pack(input logic [7:0] arr [N_CH]);
        logic [8*N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[8*c +: 8] = arr[c];
        return v;
    endfunction

    // Advance DUT and model by one clock with the currently driven inputs
    task automatic step();
        logic [7:0]        n_send [N_CH];
        logic [7:0]        n_cfg  [N_CH];
        logic [N_CH-1:0]   n_pulse, n_stat, n_en;
        logic [LED_W-1:0]  n_led;
        logic              n_irq, n_rdy;
        logic [31:0]       n_rdata;
        int                wa;
        wa = int'(wr_addr);
        n_pulse = '0;
        for (int c = 0; c < N_CH; c++) begin
            n_send[c] = m_send[c];
            n_cfg[c]  = m_cfg[c];
            if (wr_en && wa == 4 * c) begin
                if (be[1]) begin n_send[c] = wdata[15:8]; n_pulse[c] = 1'b1; end
                if (be[3]) n_cfg[c] = wdata[31:24];
            end
        end
        n_led = m_led;
        if (wr_en && wa == 4 * N_CH)
            for (int b = 0; b < LED_W; b++) if (be[b / 8]) n_led[b] = wdata[b];
        n_stat = m_stat;
        if (wr_en && wa == 4 * N_CH + 4 && be[0]) n_stat = n_stat & ~wdata[N_CH-1:0];
        n_stat = n_stat | irq_evt;
        n_en = m_en;
        if (wr_en && wa == 4 * N_CH + 8 && be[0]) n_en = wdata[N_CH-1:0];
        n_irq   = (m_stat & m_en) != 0;
        n_rdy   = rd_en;
        n_rdata = rd_en ? model_read(rd_addr) : 32'd0;
        @(posedge clk);
        #1;
        m_send = n_send; m_cfg = n_cfg; m_pulse = n_pulse; m_led = n_led;
        m_stat = n_stat; m_en = n_en; m_irq = n_irq; m_rdy = n_rdy; m_rdata = n_rdata;
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; be = '0; wr_addr = '0; rd_addr = '0; wdata = '0; irq_evt = '0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [3:0] b, input logic [31:0] d);
        wr_en = 1; wr_addr = a; be = b; wdata = d;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        rd_en = 1; rd_addr = a;
    endtask

    task automatic test_reset();
        rstb = 0;
        idle();
        uart_status = '0; uart_rcvd_byte = '0;
        model_reset();
        #12;
        checks++;
        if ({uart_send_byte, uart_send_pulse, led_b, irq, rdata, rd_rdy} !== '0) begin
            errors++;
            $display("FAIL reset_zero: send=%h pulse=%b led=%h irq=%b rdata=%h rdy=%b, all must be 0",
                     uart_send_byte, uart_send_pulse, led_b, irq, rdata, rd_rdy);
        end
        checks++;
        if (uart_cfg !== 16'h1111) begin
            errors++; $display("FAIL reset_cfg: got %h expected 1111", uart_cfg);
        end
        #1 rstb = 1;
    endtask

    task automatic test_read_ch0();
        idle();
        uart_status    = 16'h00A5;
        uart_rcvd_byte = 16'h003C;
        do_read(16'h0);
        step();
        checks++;
        if (rd_rdy !== 1'b1 || rdata !== 32'h113C00A5) begin
            errors++; $display("FAIL read_ch0: rdy=%b rdata=%h expected 1/113c00a5", rd_rdy, rdata);
        end
        idle();
        step();
        checks++;
        if (rd_rdy !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL read_idle: rdy=%b rdata=%h expected 0/0", rd_rdy, rdata);
        end
    endtask

    task automatic test_send_pulse();
        idle();
        do_write(16'h4, 4'b0010, 32'h00005A00);
        step();
        idle();
        checks++;
        if (uart_send_byte[15:8] !== 8'h5A || uart_send_pulse !== 2'b10 || uart_cfg[15:8] !== 8'h11) begin
            errors++;
            $display("FAIL send_ch1: send=%h pulse=%b cfg=%h expected 5a/10/11",
                     uart_send_byte[15:8], uart_send_pulse, uart_cfg[15:8]);
        end
        step();
        checks++;
        if (uart_send_pulse !== 2'b00) begin
            errors++; $display("FAIL send_pulse_width: pulse=%b expected 00", uart_send_pulse);
        end
    endtask

    task automatic test_led();
        idle();
        do_write(16'h8, 4'b0001, 32'hFFFFFFFF);
        step();
        checks++;
        if (led_b !== 4'hF) begin
            errors++; $display("FAIL led_write: got %h expected f", led_b);
        end
        idle();
        do_read(16'h8);
        step();
        checks++;
        if (rdata !== 32'h0000000F) begin
            errors++; $display("FAIL led_read: got %h expected 0000000f", rdata);
        end
    endtask

    task automatic test_irq();
        idle();
        do_write(16'h10, 4'b0001, 32'h1);
        step();
        idle();
        irq_evt = 2'b11;
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_early: got %b expected 0", irq);
        end
        idle();
        step();
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_assert: got %b expected 1", irq);
        end
        do_read(16'hC);
        step();
        checks++;
        if (rdata !== 32'h3) begin
            errors++; $display("FAIL irq_stat_set: got %h expected 3", rdata);
        end
        idle();
        do_write(16'hC, 4'b0001, 32'h1);
        step();
        idle();
        do_read(16'hC);
        step();
        checks++;
        if (rdata !== 32'h2 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear: stat=%h irq=%b expected 2/0", rdata, irq);
        end
    endtask

    task automatic test_set_wins();
        idle();
        irq_evt = 2'b01;
        do_write(16'hC, 4'b0001, 32'h1);
        step();
        idle();
        do_read(16'hC);
        step();
        checks++;
        if (rdata[0] !== 1'b1) begin
            errors++; $display("FAIL set_wins: stat=%h expected bit0=1", rdata);
        end
        idle();
        do_write(16'hC, 4'b0001, 32'h3);
        step();
    endtask

    task automatic test_unmapped();
        logic [15:0] s_send, s_cfg;
        logic [3:0]  s_led;
        s_send = uart_send_byte; s_cfg = uart_cfg; s_led = led_b;
        idle();
        do_read(16'h2);
        do_write(16'h2, 4'hF, 32'hFFFFFFFF);
        step();
        checks++;
        if (rd_rdy !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL read_misaligned: rdy=%b rdata=%h expected 1/0", rd_rdy, rdata);
        end
        do_read(16'h40);
        do_write(16'h40, 4'hF, 32'hFFFFFFFF);
        step();
        checks++;
        if (rd_rdy !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL read_unmapped: rdy=%b rdata=%h expected 1/0", rd_rdy, rdata);
        end
        idle();
        do_read(16'h10);
        step();
        checks++;
        if (uart_send_byte !== s_send || uart_cfg !== s_cfg || led_b !== s_led || rdata !== 32'(m_en)) begin
            errors++;
            $display("FAIL unmapped_write: send=%h cfg=%h led=%h en=%h expected %h/%h/%h/%h",
                     uart_send_byte, uart_cfg, led_b, rdata, s_send, s_cfg, s_led, m_en);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        do_write(16'h0, 4'b0010, 32'h00001100);
        step();
        checks++;
        if (uart_send_pulse !== 2'b01 || uart_send_byte[7:0] !== 8'h11) begin
            errors++; $display("FAIL b2b_first: pulse=%b send=%h expected 01/11", uart_send_pulse, uart_send_byte[7:0]);
        end
        do_write(16'h0, 4'b0010, 32'h00002200);
        do_read(16'h0);
        step();
        checks++;
        if (uart_send_pulse !== 2'b01 || uart_send_byte[7:0] !== 8'h22 || rdata[15:8] !== 8'h11) begin
            errors++;
            $display("FAIL b2b_second: pulse=%b send=%h rd_send=%h expected 01/22/11",
                     uart_send_pulse, uart_send_byte[7:0], rdata[15:8]);
        end
        idle();
        step();
        checks++;
        if (uart_send_pulse !== 2'b00 || rd_rdy !== 1'b0) begin
            errors++; $display("FAIL b2b_end: pulse=%b rdy=%b expected 00/0", uart_send_pulse, rd_rdy);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        do_write(16'h4, 4'b1010, 32'h77003300);
        do_read(16'h4);
        step();
        idle();
        rstb = 0;
        #1;
        checks++;
        if (uart_send_pulse !== '0 || uart_send_byte !== '0 || uart_cfg !== 16'h1111 ||
            rd_rdy !== 1'b0 || rdata !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: pulse=%b send=%h cfg=%h rdy=%b rdata=%h irq=%b expected reset values",
                     uart_send_pulse, uart_send_byte, uart_cfg, rd_rdy, rdata, irq);
        end
        model_reset();
        #1 rstb = 1;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] amap [8];
        amap = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h14, 16'h2, 16'h9};
        for (int i = 0; i < 400; i++) begin
            uart_status    = 16'($urandom);
            uart_rcvd_byte = 16'($urandom);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = amap[$urandom_range(0, 7)];
            be      = 4'($urandom);
            wdata   = $urandom;
            rd_en   = ($urandom_range(0, 2) != 0);
            rd_addr = amap[$urandom_range(0, 7)];
            irq_evt = ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '0;
            step();
            checks++;
            if (uart_send_byte !== pack(m_send) || uart_cfg !== pack(m_cfg) ||
                uart_send_pulse !== m_pulse || led_b !== m_led) begin
                errors++;
                $display("FAIL rand_regs[%0d]: send=%h cfg=%h pulse=%b led=%h expected %h/%h/%b/%h",
                         i, uart_send_byte, uart_cfg, uart_send_pulse, led_b,
                         pack(m_send), pack(m_cfg), m_pulse, m_led);
            end
            checks++;
            if (irq !== m_irq || rd_rdy !== m_rdy || rdata !== m_rdata) begin
                errors++;
                $display("FAIL rand_read[%0d]: irq=%b rdy=%b rdata=%h expected %b/%b/%h",
                         i, irq, rd_rdy, rdata, m_irq, m_rdy, m_rdata);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_read_ch0();
        test_send_pulse();
        test_led();
        test_irq();
        test_set_wins();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
